aes_inv_key_sched: RTL and testbench

- Iterative AES-128 round-key generator for the decryption datapath. Delivers round keys in reverse order: round 10 first, round 0 last.
- Accepts the 128-bit cipher key over a valid/ready handshake.
- Runs the forward expansion one round per cycle to reach the round-10 key.
- Then walks the schedule backwards, one round key per accepted output beat. Only 128 bits of key state are stored, not 1408.
- Sits between the key-load interface and the inverse-cipher round engine.

---
 rtl/aes_inv_key_sched_if.sv | 23 ++
 rtl/aes_inv_key_sched.sv | 157 +++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle for aes_inv_key_sched: cipher-key load side and round-key stream side.
// The slave modport is the key scheduler's view; the master modport is the driver's/consumer's view.
interface aes_inv_key_sched_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  modport master (
    output key_valid, key, rk_ready,
    input  key_ready, rk_valid, rk, rk_round, rk_last, busy
  );

  modport slave (
    input  key_valid, key, rk_ready,
    output key_ready, rk_valid, rk, rk_round, rk_last, busy
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 key scheduler producing round keys 10 down to 0 from 128 bits of state.
// Optional macro AES_INV_KEY_EQ_EN: rounds 1..9 are emitted as InvMixColumns(S) (equivalent inverse cipher keys).
module aes_inv_key_sched #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_key_sched_if.slave   bus
);

  if (NR != 10) begin : g_nr_check
    $error("aes_inv_key_sched supports only NR=10 (AES-128)");
  end

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

  state_e       state_q, state_d;
  logic [127:0] s_q, s_d;
  logic [3:0]   cnt_q, cnt_d;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  // SubWord(RotWord(w))
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] s, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = s[127:96] ^ sub_rot(s[31:0]) ^ {rc, 24'h0};
    w5 = s[95:64] ^ w4;
    w6 = s[63:32] ^ w5;
    w7 = s[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // Undoes fwd_step: the previous w3 is recoverable from w7^w6, which feeds SubWord.
  function automatic logic [127:0] inv_step(input logic [127:0] s, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = s[31:0] ^ s[63:32];
    w2 = s[63:32] ^ s[95:64];
    w1 = s[95:64] ^ s[127:96];
    w0 = s[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          s_d     = bus.key;
          cnt_d   = 4'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        s_d   = fwd_step(s_q, rcon(cnt_q + 4'd1));
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == 4'(NR)) state_d = STREAM;
      end
      STREAM: begin
        if (bus.rk_ready) begin
          if (cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            s_d   = inv_step(s_q, rcon(cnt_q));
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.rk_valid  = (state_q == STREAM);
  assign bus.rk_round  = cnt_q;
  assign bus.rk_last   = (state_q == STREAM) && (cnt_q == 4'd0);
  assign bus.busy      = (state_q != IDLE);

`ifdef AES_INV_KEY_EQ_EN
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select a, 2a, 4a, 8a (enough for 09/0b/0d/0e).
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  // Only the presented key is transformed; S keeps the raw schedule for the backward walk.
  assign bus.rk = (cnt_q >= 4'd1 && cnt_q <= 4'd9)
                ? {inv_mix_col(s_q[127:96]), inv_mix_col(s_q[95:64]),
                   inv_mix_col(s_q[63:32]), inv_mix_col(s_q[31:0])}
                : s_q;
`else
  assign bus.rk = s_q;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched with a round-key scoreboard against FIPS-197 key schedules.
module tb_aes_inv_key_sched;

  logic clk;
  logic rst_n;

  aes_inv_key_sched_if bus ();

  aes_inv_key_sched #(.NR(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] rk;
    logic [3:0]   rnd;
    logic         chk;
  } exp_t;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  exp_t         exp_q [$];
  int           n_vec;
  int           n_miss;
  logic         prev_stall;
  logic [127:0] prev_rk;
  logic [3:0]   prev_round;
  logic         prev_last;
  logic         rand_ready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef AES_INV_KEY_EQ_EN
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] x);
    logic [7:0]   row0 [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] y = '0;
    logic [31:0]  w;
    logic [7:0]   b;
    for (int c = 0; c < 4; c++) begin
      w = x[127 - 32*c -: 32];
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(w[31 - 8*j -: 8], row0[(j - i + 4) % 4]);
        y[127 - 32*c - 8*i -: 8] = b;
      end
    end
    return y;
  endfunction
`endif

  function automatic logic [127:0] expect_rk(input int r, input logic [127:0] raw);
`ifdef AES_INV_KEY_EQ_EN
    if (r >= 1 && r <= 9) return imc128(raw);
`endif
    return raw;
  endfunction

  task automatic push_k1(input int lo);
    exp_t e;
    for (int r = 10; r >= lo; r--) begin
      e.rk  = expect_rk(r, K1_RK[r]);
      e.rnd = 4'(r);
      e.chk = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_k2();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rk  = (r == 10) ? K2_R10 : K2;
      e.rnd = 4'(r);
      e.chk = (r == 10) || (r == 0);
      exp_q.push_back(e);
    end
  endtask

  // One clock: check the output side at the falling edge, return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_vld", 128'(bus.rk_valid), 128'd1);
        chk("stall_rk", bus.rk, prev_rk);
        chk("stall_round", 128'(bus.rk_round), 128'(prev_round));
        chk("stall_last", 128'(bus.rk_last), 128'(prev_last));
      end
      if (bus.rk_valid && bus.rk_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 128'(bus.rk_round), 128'hf);
        end else begin
          e = exp_q.pop_front();
          chk("rk_round", 128'(bus.rk_round), 128'(e.rnd));
          chk("rk_last", 128'(bus.rk_last), 128'(e.rnd == 4'd0));
          if (e.chk) chk("rk", bus.rk, e.rk);
        end
      end
      prev_stall = bus.rk_valid && !bus.rk_ready;
      prev_rk    = bus.rk;
      prev_round = bus.rk_round;
      prev_last  = bus.rk_last;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    logic acc = 1'b0;
    bus.key       = k;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.key_ready;
      tick();
    end
    bus.key_valid = 1'b0;
    chk("key_accepted", 128'(acc), 128'd1);
  endtask

  task automatic check_latency();
    int n = 0;
    while (!bus.rk_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'd10);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) begin
      if (rand_ready) bus.rk_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("drain_done", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    prev_stall    = 1'b0;
    prev_rk       = '0;
    prev_round    = '0;
    prev_last     = 1'b0;
    rand_ready    = 1'b0;
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.rk_ready  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", 128'(bus.key_ready), 128'd1);
    chk("rst_rk_valid", 128'(bus.rk_valid), 128'd0);
    chk("rst_rk", bus.rk, 128'd0);
    chk("rst_rk_round", 128'(bus.rk_round), 128'd0);
    chk("rst_rk_last", 128'(bus.rk_last), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    rst_n = 1'b1;
    tick();

    // Full sequence, no backpressure
    bus.rk_ready = 1'b1;
    push_k1(0);
    load(K1);
    chk("busy_after_accept", 128'(bus.busy), 128'd1);
    chk("key_ready_busy", 128'(bus.key_ready), 128'd0);
    check_latency();
    drain(40);
    chk("end_key_ready", 128'(bus.key_ready), 128'd1);
    chk("end_busy", 128'(bus.busy), 128'd0);
    chk("end_rk_valid", 128'(bus.rk_valid), 128'd0);

    // Pseudo-random backpressure
    rand_ready   = 1'b1;
    bus.rk_ready = 1'b0;
    push_k1(0);
    load(K1);
    drain(400);
    rand_ready   = 1'b0;
    bus.rk_ready = 1'b1;

    // Second key held pending while busy
    push_k1(0);
    load(K1);
    bus.key       = K2;
    bus.key_valid = 1'b1;
    push_k2();
    for (int i = 0; i < 100 && exp_q.size() > 11; i++) tick();
    chk("k2_idle_key_ready", 128'(bus.key_ready), 128'd1);
    chk("k2_idle_busy", 128'(bus.busy), 128'd0);
    tick();
    chk("k2_accept_busy", 128'(bus.busy), 128'd1);
    bus.key_valid = 1'b0;
    check_latency();
    drain(40);

    // Reset mid-stream at round 5
    push_k1(6);
    load(K1);
    for (int i = 0; i < 40 && !(bus.rk_valid && bus.rk_round == 4'd5); i++) tick();
    chk("mid_round5", 128'(bus.rk_round), 128'd5);
    chk("mid_q_empty", 128'(exp_q.size()), 128'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_rk_valid", 128'(bus.rk_valid), 128'd0);
    chk("arst_key_ready", 128'(bus.key_ready), 128'd1);
    chk("arst_rk", bus.rk, 128'd0);
    tick();
    chk("arst_rk_valid_next", 128'(bus.rk_valid), 128'd0);
    rst_n = 1'b1;
    push_k1(0);
    load(K1);
    check_latency();
    drain(40);
    chk("final_busy", 128'(bus.busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
